// File: rtl/sap1_pkg.sv
// Shared constants and state encoding for the SAP-1 memory block.
package sap1_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  // Enables from the controller are active-low throughout SAP-1.
  localparam logic EN_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PROG = 2'd2
  } state_t;

endpackage

// File: rtl/sap1_ram_array.sv
// Plain DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module sap1_ram_array #(
  parameter int ADDR_W = sap1_pkg::ADDR_W,
  parameter int DATA_W = sap1_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: contents are only ever established by writes, never by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap1_ram.sv
// SAP-1 16x8 program/data memory: clear sweep after reset, zero-latency
// reads in run mode, valid/ready loader writes in program mode.
module sap1_ram
  import sap1_pkg::*;
#(
  parameter int ADDR_W = sap1_pkg::ADDR_W,
  parameter int DATA_W = sap1_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ce,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic              prog_mode,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_done,
  output logic [ADDR_W:0]   wr_cnt,
  output logic              busy
);

  localparam int              DEPTH_L = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH_L);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              sweep_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign sweep_last = (ptr == ADDR_W'(DEPTH_L - 1));

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  // Next-state logic. Sweep end always lands in RUN, so PROG is one cycle later.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT: if (sweep_last) state_nxt = ST_RUN;
      ST_RUN:  if (prog_mode)  state_nxt = ST_PROG;
      ST_PROG: if (!prog_mode) state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Output decode; reads are combinational so data is valid in the ce cycle.
  always_comb begin
    busy       = (state == ST_INIT);
    prog_ready = (state == ST_PROG);
    bus_oe     = (state == ST_RUN) && (ce == EN_ACTIVE);
    bus_out    = bus_oe ? mem_rdata : '0;
  end

  // Write port steering: the sweep writes zeros, the loader writes in PROG.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr;
    mem_wdata = '0;
    if (state == ST_INIT) begin
      mem_we = 1'b1;
    end else if (state == ST_PROG && prog_valid) begin
      mem_we    = 1'b1;
      mem_waddr = prog_addr;
      mem_wdata = prog_data;
    end
  end

  // Sweep pointer walks every location once per reset.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                 ptr <= '0;
    else if (state == ST_INIT)  ptr <= ptr + 1'b1;
  end

  // Session write counter: cleared on PROG entry, saturates at DEPTH, held in RUN.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_cnt <= '0;
    end else if (state == ST_RUN && prog_mode) begin
      wr_cnt <= '0;
    end else if (state == ST_PROG && prog_valid && wr_cnt != CNT_MAX) begin
      wr_cnt <= wr_cnt + 1'b1;
    end
  end

  // One-cycle pulse after the edge that leaves PROG.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) prog_done <= 1'b0;
    else        prog_done <= (state == ST_PROG) && !prog_mode;
  end

  sap1_ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (addr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_sap1_ram.sv
// Self-checking bench for sap1_ram: reference model plus directed vectors.
module tb_sap1_ram;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [3:0] addr = 4'd0;
  logic       ce = 1'b1;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       prog_mode = 1'b0;
  logic       prog_valid = 1'b0;
  logic       prog_ready;
  logic [3:0] prog_addr = 4'd0;
  logic [7:0] prog_data = 8'd0;
  logic       prog_done;
  logic [4:0] wr_cnt;
  logic       busy;

  int total = 0;
  int bad = 0;

  sap1_ram dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .addr       (addr),
    .ce         (ce),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .prog_mode  (prog_mode),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_done  (prog_done),
    .wr_cnt     (wr_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles left in the sweep, a program-session flag,
  // the session count, the done pulse and a plain copy of the memory.
  int         m_sweep = 16;
  bit         m_prog = 1'b0;
  bit         m_done = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_mem [16];

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_sweep <= 16;
      m_prog  <= 1'b0;
      m_done  <= 1'b0;
      m_cnt   <= 0;
    end else if (m_sweep > 0) begin
      m_mem[16 - m_sweep] <= 8'h00;
      m_sweep <= m_sweep - 1;
      m_done  <= 1'b0;
    end else if (!m_prog) begin
      m_done <= 1'b0;
      if (prog_mode) begin
        m_prog <= 1'b1;
        m_cnt  <= 0;
      end
    end else begin
      if (prog_valid) begin
        m_mem[prog_addr] <= prog_data;
        if (m_cnt < 16) m_cnt <= m_cnt + 1;
      end
      m_prog <= prog_mode;
      m_done <= !prog_mode;
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic       e_busy, e_ready, e_oe;
    logic [7:0] e_out;
    e_busy  = (m_sweep > 0);
    e_ready = !e_busy && m_prog;
    e_oe    = !e_busy && !m_prog && (ce == 1'b0);
    e_out   = e_oe ? m_mem[addr] : 8'h00;
    chk("model_busy", {31'd0, busy}, {31'd0, e_busy});
    chk("model_ready", {31'd0, prog_ready}, {31'd0, e_ready});
    chk("model_oe", {31'd0, bus_oe}, {31'd0, e_oe});
    chk("model_out", {24'd0, bus_out}, {24'd0, e_out});
    chk("model_done", {31'd0, prog_done}, {31'd0, m_done});
    chk("model_cnt", {27'd0, wr_cnt}, m_cnt);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    prog_valid = 1'b1;
    prog_addr  = a;
    prog_data  = d;
    step();
    prog_valid = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_oe", {31'd0, bus_oe}, 32'd0);
    chk("rst_out", {24'd0, bus_out}, 32'd0);
    chk("rst_ready", {31'd0, prog_ready}, 32'd0);
    chk("rst_cnt", {27'd0, wr_cnt}, 32'd0);
    step();
    step();

    // 1: sweep with a read already requested
    ce = 1'b0;
    addr = 4'd5;
    clr_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("sweep_busy", {31'd0, busy}, 32'd1);
      chk("sweep_oe", {31'd0, bus_oe}, 32'd0);
      step();
    end
    chk("run_busy", {31'd0, busy}, 32'd0);
    chk("run_oe", {31'd0, bus_oe}, 32'd1);
    chk("run_zero", {24'd0, bus_out}, 32'h00);

    // 2 and 3: session with rewrite; ce held low in PROG
    addr = 4'd3;
    prog_mode = 1'b1;
    step();
    chk("prog_ready", {31'd0, prog_ready}, 32'd1);
    chk("prog_oe_ce0", {31'd0, bus_oe}, 32'd0);
    wr(4'h3, 8'hA7);
    chk("prog_oe_ce0b", {31'd0, bus_oe}, 32'd0);
    wr(4'h3, 8'h5C);
    wr(4'hF, 8'h11);
    prog_mode = 1'b0;
    step();
    #1;
    chk("s2_cnt", {27'd0, wr_cnt}, 32'd3);
    chk("s2_done", {31'd0, prog_done}, 32'd1);
    chk("s2_oe_back", {31'd0, bus_oe}, 32'd1);
    chk("s2_rd3", {24'd0, bus_out}, 32'h5C);
    addr = 4'hF;
    #1;
    chk("s2_rdF", {24'd0, bus_out}, 32'h11);
    step();
    chk("s2_done_end", {31'd0, prog_done}, 32'd0);
    ce = 1'b1;
    #1;
    chk("ce_high_oe", {31'd0, bus_oe}, 32'd0);
    chk("ce_high_out", {24'd0, bus_out}, 32'd0);
    ce = 1'b0;
    #1;
    chk("ce_low_oe", {31'd0, bus_oe}, 32'd1);

    // 4: saturation, then a new session clears the count
    prog_mode = 1'b1;
    step();
    chk("s4_cnt0", {27'd0, wr_cnt}, 32'd0);
    for (int i = 0; i < 20; i++) wr(4'(i), 8'(8'h30 + i));
    chk("s4_sat", {27'd0, wr_cnt}, 32'd16);
    prog_mode = 1'b0;
    step();
    chk("s4_hold", {27'd0, wr_cnt}, 32'd16);
    addr = 4'd2;
    #1;
    chk("s4_rd2", {24'd0, bus_out}, 32'h42);
    prog_mode = 1'b1;
    step();
    chk("s4_clear", {27'd0, wr_cnt}, 32'd0);

    // 5: reset pulse in the middle of a write burst
    wr(4'h1, 8'hEE);
    prog_valid = 1'b1;
    prog_addr  = 4'h2;
    prog_data  = 8'hDD;
    clr_n = 1'b0;
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_ready", {31'd0, prog_ready}, 32'd0);
    chk("mid_cnt", {27'd0, wr_cnt}, 32'd0);
    chk("mid_done", {31'd0, prog_done}, 32'd0);
    chk("mid_oe", {31'd0, bus_oe}, 32'd0);
    clr_n = 1'b1;
    prog_valid = 1'b0;
    prog_mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("s5_nodone", {31'd0, prog_done}, 32'd0);
      step();
    end
    chk("s5_busy", {31'd0, busy}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      #1;
      chk("s5_zero", {24'd0, bus_out}, 32'h00);
    end

    // 6: prog_mode held through the sweep; write on the exit edge
    prog_mode = 1'b1;
    clr_n = 1'b0;
    #1;
    clr_n = 1'b1;
    for (int i = 0; i < 16; i++) step();
    chk("s6_run", {31'd0, busy}, 32'd0);
    chk("s6_not_ready", {31'd0, prog_ready}, 32'd0);
    step();
    chk("s6_ready", {31'd0, prog_ready}, 32'd1);
    wr(4'h7, 8'h9E);
    prog_mode = 1'b0;
    wr(4'h8, 8'h42);
    #1;
    chk("s6_done", {31'd0, prog_done}, 32'd1);
    chk("s6_cnt", {27'd0, wr_cnt}, 32'd2);
    addr = 4'h8;
    #1;
    chk("s6_rd8", {24'd0, bus_out}, 32'h42);
    addr = 4'h7;
    #1;
    chk("s6_rd7", {24'd0, bus_out}, 32'h9E);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
